// File: rtl/injector_seq_pkg.sv
// Shared types and constants for the bias injector sequencer.
// State encodings, config register addresses and reset values.
package injector_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] ADDR_TRIM    = 2'd0;
    localparam logic [1:0] ADDR_HI_W    = 2'd1;
    localparam logic [1:0] ADDR_LO_W    = 2'd2;
    localparam logic [1:0] ADDR_N_PULSE = 2'd3;

    localparam logic [7:0] RST_TRIM = 8'h00;
    localparam int         RST_CNT  = 1;

endpackage

// File: rtl/injector_seq_timer.sv
// Shared phase timer for the injector sequencer.
// Down-counter with load, enable and a registered zero flag.
module injector_seq_timer
    import injector_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic         zero_q;

    // Load wins over count; the zero flag tracks the next count value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (load_i) begin
            cnt_q  <= val_i;
            zero_q <= (val_i == '0);
        end else if (en_i && !zero_q) begin
            cnt_q  <= cnt_q - W'(1);
            zero_q <= (cnt_q == W'(1));
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/injector_seq.sv
// Bias injector sequencer: trim shadowing, settle delay and pulse bursts.
// Outputs are registered from the next state so they change on state entry.
module injector_seq
    import injector_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    output logic [CNT_W-1:0] cfg_rdata,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_done,
    output logic             inj_enable,
    output logic [3:0]       inj_trim_p,
    output logic [3:0]       inj_trim_n,
    output logic             inj_signal
);

    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] w);
        return (w == '0) ? '0 : w - ONE;
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       trim_sh_q;
    logic [CNT_W-1:0] hi_q, lo_q, np_q;
    logic [CNT_W-1:0] run_hi_q, run_lo_q, run_np_q;
    logic [CNT_W-1:0] pd_q;
    logic [3:0]       trim_p_q, trim_n_q;
    logic             act_q, sig_q, done_q;

    logic             tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic             run_latch, pulse_inc;

    injector_seq_timer #(.W(CNT_W)) u_timer (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .val_i  (tmr_val),
        .zero_o (tmr_zero)
    );

    // Next state, timer reloads on every state entry, abort override.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = '0;
        run_latch = 1'b0;
        pulse_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d   = ST_SETTLE;
                    tmr_load  = 1'b1;
                    tmr_val   = SETTLE_M1;
                    run_latch = 1'b1;
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = eff_m1(run_hi_q);
                end
            end
            ST_HIGH: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = eff_m1(run_lo_q);
                end
            end
            ST_LOW: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    pulse_inc = 1'b1;
                    if (run_np_q != '0 && pd_q + ONE == run_np_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = eff_m1(run_hi_q);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (stop && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            tmr_load  = 1'b0;
            pulse_inc = 1'b0;
        end
    end

    // State, run copies, pulse counter and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            run_hi_q <= CNT_W'(RST_CNT);
            run_lo_q <= CNT_W'(RST_CNT);
            run_np_q <= CNT_W'(RST_CNT);
            pd_q     <= '0;
            act_q    <= 1'b0;
            sig_q    <= 1'b0;
            done_q   <= 1'b0;
            trim_p_q <= '0;
            trim_n_q <= '0;
        end else begin
            state_q <= state_d;
            if (run_latch) begin
                run_hi_q <= hi_q;
                run_lo_q <= lo_q;
                run_np_q <= np_q;
                pd_q     <= '0;
            end else if (pulse_inc) begin
                pd_q <= pd_q + ONE;
            end
            act_q  <= (state_d != ST_IDLE);
            sig_q  <= (state_d == ST_HIGH);
            done_q <= (state_d == ST_DONE);
            if (state_q == ST_IDLE) begin
                trim_p_q <= trim_sh_q[3:0];
                trim_n_q <= trim_sh_q[7:4];
            end
        end
    end

    // Config register file written by the bus side.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            trim_sh_q <= RST_TRIM;
            hi_q      <= CNT_W'(RST_CNT);
            lo_q      <= CNT_W'(RST_CNT);
            np_q      <= CNT_W'(RST_CNT);
        end else if (cfg_we) begin
            unique case (cfg_addr)
                ADDR_TRIM:    trim_sh_q <= 8'(cfg_wdata);
                ADDR_HI_W:    hi_q      <= cfg_wdata;
                ADDR_LO_W:    lo_q      <= cfg_wdata;
                ADDR_N_PULSE: np_q      <= cfg_wdata;
                default:      ;
            endcase
        end
    end

    // Combinational readback of the addressed config register.
    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            ADDR_TRIM:    cfg_rdata = CNT_W'(trim_sh_q);
            ADDR_HI_W:    cfg_rdata = hi_q;
            ADDR_LO_W:    cfg_rdata = lo_q;
            ADDR_N_PULSE: cfg_rdata = np_q;
            default:      cfg_rdata = '0;
        endcase
    end

    assign busy        = act_q;
    assign inj_enable  = act_q;
    assign inj_signal  = sig_q;
    assign done        = done_q;
    assign pulses_done = pd_q;
    assign inj_trim_p  = trim_p_q;
    assign inj_trim_n  = trim_n_q;

endmodule

// File: tb/tb_injector_seq.sv
// Self-checking bench for injector_seq.
// Per-cycle outputs are compared against a timeline model of each run.
module tb_injector_seq;

    localparam int S = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic [7:0] cfg_rdata;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy, done, inj_enable, inj_signal;
    logic [7:0] pulses_done;
    logic [3:0] tp, tn;

    int total = 0;
    int bad = 0;

    logic [7:0] sh_trim = 8'h00;
    int m_hi = 1;
    int m_lo = 1;
    int m_n = 1;

    injector_seq #(.SETTLE_CYC(S), .CNT_W(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .done        (done),
        .pulses_done (pulses_done),
        .inj_enable  (inj_enable),
        .inj_trim_p  (tp),
        .inj_trim_n  (tn),
        .inj_signal  (inj_signal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       sig;
        logic       dn;
        logic       bsy;
        logic [7:0] pd;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs k cycles after the accepted start edge.
    function automatic exp_t model(int k, int h, int l, int n);
        exp_t e;
        int t, p;
        e = '0;
        p = h + l;
        if (k < S) begin
            e.en = 1'b1;
            e.bsy = 1'b1;
        end else begin
            t = k - S;
            if (n != 0 && t >= n * p) begin
                e.pd = 8'(n);
                if (t == n * p) begin
                    e.en = 1'b1;
                    e.dn = 1'b1;
                    e.bsy = 1'b1;
                end
            end else begin
                e.en = 1'b1;
                e.bsy = 1'b1;
                e.sig = ((t % p) < h);
                e.pd = 8'(t / p);
            end
        end
        return e;
    endfunction

    task automatic wr(input logic [1:0] a, input int v);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = 8'(v);
        @(negedge clk);
        cfg_we = 1'b0;
        case (a)
            2'd0: sh_trim = 8'(v);
            2'd1: m_hi = v & 255;
            2'd2: m_lo = v & 255;
            default: m_n = v & 255;
        endcase
    endtask

    task automatic chk_regs(input string tag);
        int e;
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            e = (a == 0) ? int'(sh_trim) : (a == 1) ? m_hi :
                (a == 2) ? m_lo : m_n;
            chk($sformatf("%s rdata[%0d]", tag, a), 32'(cfg_rdata), 32'(e));
        end
    endtask

    task automatic chk_out0(input string tag);
        chk({tag, " en"}, 32'(inj_enable), 0);
        chk({tag, " sig"}, 32'(inj_signal), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " pd"}, 32'(pulses_done), 0);
        chk({tag, " trim_p"}, 32'(tp), 0);
        chk({tag, " trim_n"}, 32'(tn), 0);
    endtask

    // One start-to-idle run; caller is aligned to a falling edge.
    task automatic do_run(input int stop_at, input int again_at,
                          input int wtrim_at, input logic [7:0] wtrim_v,
                          input bit whi, input int whi_v,
                          output int bcnt);
        int h, l, n, ki, kmax;
        exp_t e, es;
        logic [7:0] tfz;
        h = (m_hi == 0) ? 1 : m_hi;
        l = (m_lo == 0) ? 1 : m_lo;
        n = m_n;
        tfz = sh_trim;
        bcnt = 0;
        ki = (stop_at >= 0) ? stop_at + 1 : S + n * (h + l) + 1;
        kmax = ki + 2;
        es = (stop_at >= 0) ? model(stop_at, h, l, n) : '0;
        start = 1'b1;
        if (whi) begin
            cfg_we = 1'b1;
            cfg_addr = 2'd1;
            cfg_wdata = 8'(whi_v);
            m_hi = whi_v;
        end
        @(negedge clk);
        for (int k = 0; k < kmax; k++) begin
            start = 1'b0;
            stop = 1'b0;
            cfg_we = 1'b0;
            if (stop_at >= 0 && k > stop_at) begin
                e = '0;
                e.pd = es.pd;
            end else begin
                e = model(k, h, l, n);
            end
            chk($sformatf("en k=%0d", k), 32'(inj_enable), 32'(e.en));
            chk($sformatf("sig k=%0d", k), 32'(inj_signal), 32'(e.sig));
            chk($sformatf("done k=%0d", k), 32'(done), 32'(e.dn));
            chk($sformatf("busy k=%0d", k), 32'(busy), 32'(e.bsy));
            chk($sformatf("pd k=%0d", k), 32'(pulses_done), 32'(e.pd));
            chk($sformatf("trim_p k=%0d", k), 32'(tp),
                32'((k <= ki) ? tfz[3:0] : sh_trim[3:0]));
            chk($sformatf("trim_n k=%0d", k), 32'(tn),
                32'((k <= ki) ? tfz[7:4] : sh_trim[7:4]));
            if (busy === 1'b1) bcnt++;
            if (k == stop_at) stop = 1'b1;
            if (k == again_at) start = 1'b1;
            if (k == wtrim_at) begin
                cfg_we = 1'b1;
                cfg_addr = 2'd0;
                cfg_wdata = wtrim_v;
                sh_trim = wtrim_v;
            end
            @(negedge clk);
        end
        start = 1'b0;
        stop = 1'b0;
        cfg_we = 1'b0;
    endtask

    initial begin
        int b, sa;
        repeat (3) @(negedge clk);
        chk_out0("reset");
        rst = 1'b0;
        chk_regs("reset");
        @(negedge clk);
        chk_out0("post_reset");

        wr(2'd0, 8'hA5);
        chk("trim_lag_p", 32'(tp), 0);
        @(negedge clk);
        chk("trim_p", 32'(tp), 32'h5);
        chk("trim_n", 32'(tn), 32'hA);
        wr(2'd1, 3);
        wr(2'd2, 2);
        wr(2'd3, 4);
        chk_regs("cfg");
        do_run(-1, -1, -1, 8'h00, 1'b0, 0, b);
        chk("busy_len_4x5", 32'(b), 32'(S + 4 * 5 + 1));
        chk("pd_after", 32'(pulses_done), 4);

        wr(2'd1, 0);
        wr(2'd2, 0);
        wr(2'd3, 2);
        do_run(-1, -1, -1, 8'h00, 1'b0, 0, b);
        chk("busy_len_zero_w", 32'(b), 21);

        wr(2'd1, 2);
        wr(2'd2, 1);
        wr(2'd3, 0);
        do_run(40, -1, -1, 8'h00, 1'b0, 0, b);
        chk("busy_len_stop", 32'(b), 41);

        wr(2'd1, 3);
        wr(2'd2, 2);
        wr(2'd3, 2);
        do_run(-1, -1, S, 8'h3C, 1'b0, 0, b);
        chk("trim_3c_p", 32'(tp), 32'hC);
        chk("trim_3c_n", 32'(tn), 32'h3);

        do_run(-1, 5, -1, 8'h00, 1'b0, 0, b);
        do_run(-1, S + 2 * 5, -1, 8'h00, 1'b0, 0, b);

        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("startstop busy", 32'(busy), 0);
        chk("startstop en", 32'(inj_enable), 0);
        @(negedge clk);
        chk("startstop busy2", 32'(busy), 0);

        wr(2'd1, 2);
        wr(2'd2, 1);
        wr(2'd3, 2);
        do_run(-1, -1, -1, 8'h00, 1'b1, 5, b);
        chk("busy_len_wr_start", 32'(b), 32'(S + 2 * 3 + 1));
        chk_regs("wr_start");

        for (int r = 0; r < 8; r++) begin
            wr(2'd0, int'($urandom_range(0, 255)));
            wr(2'd1, int'($urandom_range(0, 4)));
            wr(2'd2, int'($urandom_range(0, 4)));
            wr(2'd3, int'($urandom_range(0, 5)));
            sa = (m_n == 0) ? int'($urandom_range(0, 60)) : -1;
            do_run(sa, -1, -1, 8'h00, 1'b0, 0, b);
            chk_regs("rand");
        end

        wr(2'd1, 1);
        wr(2'd2, 1);
        wr(2'd3, 0);
        do_run(S + 2 * 257, -1, -1, 8'h00, 1'b0, 0, b);
        chk("pd_wrap", 32'(pulses_done), 1);

        wr(2'd0, 8'h96);
        wr(2'd1, 3);
        wr(2'd2, 2);
        wr(2'd3, 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 3) @(negedge clk);
        chk("pre_rst sig", 32'(inj_signal), 0);
        chk("pre_rst busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        sh_trim = 8'h00;
        m_hi = 1;
        m_lo = 1;
        m_n = 1;
        chk_out0("mid_rst");
        chk_regs("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        chk_out0("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
